// File: rtl/ip_pkg.sv
// ip_pkg: IPv4 header constants shared by the RX decapsulator and the TX
// encapsulator, the RX state encoding, and the ones-complement fold helper.
package ip_pkg;

    // Fixed IPv4 header layout: version 4, IHL 5 (20 bytes, no options)
    localparam logic [3:0]  IP_VERSION     = 4'd4;
    localparam logic [3:0]  IP_IHL         = 4'd5;
    localparam logic [7:0]  IP_VER_IHL     = {IP_VERSION, IP_IHL};
    localparam logic [15:0] IP_HDR_LEN     = 16'd20;
    localparam logic [4:0]  IP_HDR_LAST    = 5'd19;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_TTL_DEFAULT = 8'd64;
    localparam logic [2:0]  IP_FLAGS_DF    = 3'b010;
    localparam logic [31:0] IP_BCAST_ADDR  = 32'hFFFF_FFFF;

    // RX state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_PAD     = 3'd3;
    localparam logic [2:0] ST_DROP    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_HEADER  = ST_HEADER,
        S_PAYLOAD = ST_PAYLOAD,
        S_PAD     = ST_PAD,
        S_DROP    = ST_DROP
    } ip_rx_state_e;

    // Two-step end-around-carry fold of a 20-bit sum of 16-bit words.
    // Ten header words keep the raw sum below 2^20, so two folds suffice.
    function automatic logic [15:0] csum_fold(input logic [19:0] acc);
        logic [16:0] f;
        f = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        f = {1'b0, f[15:0]} + {16'd0, f[16]};
        return f[15:0];
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc: 16-bit ones-complement accumulator fed one byte at a time.
// Even bytes are held as the high half of a word; each odd byte completes the
// word and adds it into a 20-bit raw sum. o_fold is the folded sum including
// the word completed by the current odd byte, so the caller can judge the
// checksum on the same beat that delivers the last header byte.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_valid         a byte is presented this cycle
//   i_clear         this byte starts a new sum (it is word 0's high byte)
//   i_odd           this byte is the low half of a word
//   i_byte          data byte
//   o_fold          folded 16-bit ones-complement sum
module ip_csum_acc
    import ip_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_clear,
    input  logic        i_odd,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_fold
);

    logic [7:0]  r_hi;
    logic [19:0] r_acc;
    logic [19:0] w_sum;

    assign w_sum  = r_acc + ((i_valid && i_odd) ? {4'd0, r_hi, i_byte} : 20'd0);
    assign o_fold = csum_fold(w_sum);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi  <= 8'd0;
            r_acc <= 20'd0;
        end else if (i_valid) begin
            if (i_clear) begin
                r_hi  <= i_byte;
                r_acc <= 20'd0;
            end else if (i_odd) begin
                r_acc <= w_sum;
            end else begin
                r_hi  <= i_byte;
            end
        end
    end

endmodule

// File: rtl/ip_datagram_rx.sv
// ip_datagram_rx: receive-side IPv4 decapsulator.
// Parses and validates a 20-byte IPv4 header from an AXI-Stream byte stream
// (tuser marks header byte 0), then forwards only the payload with zero
// latency, tuser on its first byte and tlast at Total Length. Rejected
// datagrams and Ethernet padding past Total Length are consumed silently.
// Ports:
//   s_axis_aclk / s_axis_reset  clock, synchronous active-high reset
//   ip_enable                   0 = combinational bypass, 1 = decapsulate
//   IP_LocalAddr                destination address filter
//   s_axis_*                    input byte stream
//   m_axis_*                    payload byte stream
//   IP_SrcAddr / IP_TotLen      fields of the last accepted datagram
//   hdr_valid / hdr_drop        1-cycle pulses: header accepted / rejected
//   err_trunc                   1-cycle pulse: frame ended before Total Length
module ip_datagram_rx
    import ip_pkg::*;
#(
    parameter logic [7:0] IP_PROTOCOL  = 8'd17,
    parameter bit         ACCEPT_BCAST = 1'b1
)(
    input  logic        s_axis_aclk,
    input  logic        s_axis_reset,
    input  logic        ip_enable,
    input  logic [31:0] IP_LocalAddr,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [31:0] IP_SrcAddr,
    output logic [15:0] IP_TotLen,
    output logic        hdr_valid,
    output logic        hdr_drop,
    output logic        err_trunc
);

    ip_rx_state_e r_state;
    logic [4:0]   r_cnt;          // index of the header byte expected next
    logic [7:0]   r_ver_ihl;
    logic [7:0]   r_proto;
    logic [15:0]  r_totlen_hdr;
    logic [31:0]  r_src_hdr;
    logic [31:0]  r_dst_hdr;      // bytes 16-18; byte 19 is taken live
    logic [15:0]  r_remaining;    // payload bytes still owed downstream
    logic         r_first;
    logic [31:0]  r_ip_src;
    logic [15:0]  r_ip_totlen;
    logic         r_hdr_valid;
    logic         r_hdr_drop;
    logic         r_err_trunc;

    logic         w_beat;
    logic         w_sof;
    logic         w_csum_vld;
    logic [15:0]  w_fold;
    logic [31:0]  w_dst;
    logic         w_dst_ok;
    logic         w_accept;
    logic         w_last_pay;

    assign w_beat     = s_axis_tvalid & s_axis_tready;
    assign w_sof      = (r_state == S_IDLE) && s_axis_tuser;
    assign w_csum_vld = ip_enable && w_beat && (w_sof || r_state == S_HEADER);
    assign w_dst      = {r_dst_hdr[23:0], s_axis_tdata};
    assign w_dst_ok   = (w_dst == IP_LocalAddr) ||
                        (ACCEPT_BCAST && (w_dst == IP_BCAST_ADDR));
    assign w_accept   = (r_ver_ihl == IP_VER_IHL) &&
                        (r_proto == IP_PROTOCOL) &&
                        (r_totlen_hdr >= IP_HDR_LEN + 16'd1) &&
                        (w_fold == 16'hFFFF) &&
                        w_dst_ok;
    assign w_last_pay = (r_remaining == 16'd1);

    // Byte 0 always arrives in IDLE and is even; in HEADER r_cnt is the
    // index of the byte on the bus, so its LSB tells even/odd.
    ip_csum_acc u_csum (
        .i_clk   (s_axis_aclk),
        .i_reset (s_axis_reset),
        .i_valid (w_csum_vld),
        .i_clear (r_state == S_IDLE),
        .i_odd   ((r_state == S_HEADER) && r_cnt[0]),
        .i_byte  (s_axis_tdata),
        .o_fold  (w_fold)
    );

    // Stream datapath is combinational so the payload passes with no latency
    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b1;
        if (!ip_enable) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser;
            s_axis_tready = m_axis_tready;
        end else if (r_state == S_PAYLOAD) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast | w_last_pay;
            m_axis_tuser  = r_first;
            s_axis_tready = m_axis_tready;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_ver_ihl    <= 8'd0;
            r_proto      <= 8'd0;
            r_totlen_hdr <= 16'd0;
            r_src_hdr    <= 32'd0;
            r_dst_hdr    <= 32'd0;
            r_remaining  <= 16'd0;
            r_first      <= 1'b0;
            r_ip_src     <= 32'd0;
            r_ip_totlen  <= 16'd0;
            r_hdr_valid  <= 1'b0;
            r_hdr_drop   <= 1'b0;
            r_err_trunc  <= 1'b0;
        end else begin
            r_hdr_valid <= 1'b0;
            r_hdr_drop  <= 1'b0;
            r_err_trunc <= 1'b0;
            if (!ip_enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_beat && s_axis_tuser) begin
                            r_ver_ihl <= s_axis_tdata;
                            r_cnt     <= 5'd1;
                            // A one-byte frame cannot hold a header
                            if (s_axis_tlast) r_hdr_drop <= 1'b1;
                            else              r_state    <= S_HEADER;
                        end
                    end
                    S_HEADER: begin
                        if (w_beat) begin
                            r_cnt <= r_cnt + 5'd1;
                            case (r_cnt)
                                5'd2:  r_totlen_hdr[15:8] <= s_axis_tdata;
                                5'd3:  r_totlen_hdr[7:0]  <= s_axis_tdata;
                                5'd9:  r_proto            <= s_axis_tdata;
                                5'd12, 5'd13, 5'd14, 5'd15:
                                       r_src_hdr <= {r_src_hdr[23:0], s_axis_tdata};
                                5'd16, 5'd17, 5'd18, 5'd19:
                                       r_dst_hdr <= {r_dst_hdr[23:0], s_axis_tdata};
                                default: ;
                            endcase
                            if (r_cnt == IP_HDR_LAST) begin
                                if (w_accept) begin
                                    r_hdr_valid <= 1'b1;
                                    r_ip_src    <= r_src_hdr;
                                    r_ip_totlen <= r_totlen_hdr;
                                    r_remaining <= r_totlen_hdr - IP_HDR_LEN;
                                    r_first     <= 1'b1;
                                    // Good header but no payload bytes at all
                                    if (s_axis_tlast) begin
                                        r_err_trunc <= 1'b1;
                                        r_state     <= S_IDLE;
                                    end else begin
                                        r_state     <= S_PAYLOAD;
                                    end
                                end else begin
                                    r_hdr_drop <= 1'b1;
                                    r_state    <= s_axis_tlast ? S_IDLE : S_DROP;
                                end
                            end else if (s_axis_tlast) begin
                                r_hdr_drop <= 1'b1;
                                r_state    <= S_IDLE;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_beat) begin
                            r_remaining <= r_remaining - 16'd1;
                            r_first     <= 1'b0;
                            if (w_last_pay) begin
                                r_state <= s_axis_tlast ? S_IDLE : S_PAD;
                            end else if (s_axis_tlast) begin
                                r_err_trunc <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end
                    end
                    S_PAD, S_DROP: begin
                        if (w_beat && s_axis_tlast) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign IP_SrcAddr = r_ip_src;
    assign IP_TotLen  = r_ip_totlen;
    assign hdr_valid  = r_hdr_valid;
    assign hdr_drop   = r_hdr_drop;
    assign err_trunc  = r_err_trunc;

endmodule

// File: tb/tb_ip_datagram_rx.sv
// tb_ip_datagram_rx: directed and throttled-random checks of ip_datagram_rx
// against a frame-level model of IPv4 decapsulation.
module tb_ip_datagram_rx;

    localparam logic [31:0] LOCAL = 32'hC0A8_0164;

    logic        clk = 1'b0;
    logic        rst;
    logic        ip_en;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser, m_tready;
    logic [31:0] src_addr;
    logic [15:0] tot_len;
    logic        hv, hd, et;

    logic        throttle = 1'b0;
    logic        m_rdy_set;
    logic        m_rnd = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) m_rnd <= 1'($urandom_range(0, 1));
    assign m_tready = throttle ? m_rnd : m_rdy_set;

    ip_datagram_rx #(.IP_PROTOCOL(8'd17), .ACCEPT_BCAST(1'b1)) dut (
        .s_axis_aclk   (clk),
        .s_axis_reset  (rst),
        .ip_enable     (ip_en),
        .IP_LocalAddr  (LOCAL),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .IP_SrcAddr    (src_addr),
        .IP_TotLen     (tot_len),
        .hdr_valid     (hv),
        .hdr_drop      (hd),
        .err_trunc     (et)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } ob_t;

    int checks = 0;
    int errors = 0;

    // Model state
    ob_t         exp_q[$];
    logic [7:0]  frm[$];
    int          e_hv = 0, e_drop = 0, e_trunc = 0;
    logic [31:0] m_src = 32'd0;
    logic [15:0] m_tl  = 16'd0;

    // Observed event counters
    int n_hv = 0, n_drop = 0, n_trunc = 0, n_vld = 0, n_stall = 0, n_out = 0;
    ob_t cmp_e;

    // Header from the worked example: checksum B70A
    logic [7:0] t1h [20] = '{8'h45, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h40, 8'h00,
                             8'h40, 8'h11, 8'hB7, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h0A,
                             8'hC0, 8'hA8, 8'h01, 8'h64};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every output beat against the model's byte queue
    always @(negedge clk) begin
        if (!rst && ip_en) begin
            if (m_tvalid && m_tready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: got data %0h user %0b last %0b, none expected",
                             m_tdata, m_tuser, m_tlast);
                end else begin
                    cmp_e = exp_q.pop_front();
                    if ({m_tdata, m_tuser, m_tlast} !== cmp_e) begin
                        errors++;
                        $display("FAIL out_beat: got d=%0h u=%0b l=%0b expected d=%0h u=%0b l=%0b",
                                 m_tdata, m_tuser, m_tlast, cmp_e.d, cmp_e.u, cmp_e.l);
                    end
                end
            end
            if (hv) n_hv++;
            if (hd) n_drop++;
            if (et) n_trunc++;
            if (m_tvalid) n_vld++;
            if (s_tvalid && !s_tready) n_stall++;
        end
    end

    // Frame-level model: what the whole frame in frm must produce
    task automatic model_frame();
        int n, plen, avail, k;
        logic [31:0] sum, src, dst;
        logic [15:0] tl;
        bit ok;
        ob_t t;
        n = frm.size();
        if (n < 20) begin
            e_drop++;
            return;
        end
        sum = 32'd0;
        for (int i = 0; i < 10; i++) sum += {16'd0, frm[2*i], frm[2*i+1]};
        while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        tl  = {frm[2], frm[3]};
        src = {frm[12], frm[13], frm[14], frm[15]};
        dst = {frm[16], frm[17], frm[18], frm[19]};
        ok  = (frm[0] == 8'h45) && (frm[9] == 8'd17) && (tl >= 16'd21) &&
              (sum == 32'h0000_FFFF) && (dst == LOCAL || dst == 32'hFFFF_FFFF);
        if (!ok) begin
            e_drop++;
            return;
        end
        e_hv++;
        m_src = src;
        m_tl  = tl;
        plen  = int'(tl) - 20;
        avail = n - 20;
        k     = (avail < plen) ? avail : plen;
        if (avail < plen) e_trunc++;
        for (int i = 0; i < k; i++) begin
            t.d = frm[20+i];
            t.u = (i == 0);
            t.l = (i == k - 1);
            exp_q.push_back(t);
        end
    endtask

    task automatic mk_hdr(input logic [7:0] ver, input logic [15:0] tl, input logic [7:0] proto,
                          input logic [31:0] src, input logic [31:0] dst, input bit bad);
        logic [7:0]  h [20];
        logic [31:0] s;
        logic [15:0] cs;
        h = '{ver, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, proto,
              8'h00, 8'h00, src[31:24], src[23:16], src[15:8], src[7:0],
              dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
        s = 32'd0;
        for (int i = 0; i < 10; i++) s += {16'd0, h[2*i], h[2*i+1]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        cs = ~s[15:0];
        if (bad) cs = cs ^ 16'h0001;
        h[10] = cs[15:8];
        h[11] = cs[7:0];
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(h[i]);
    endtask

    task automatic load_t1();
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(t1h[i]);
    endtask

    task automatic add_pay(input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) frm.push_back(start + 8'(i));
    endtask

    task automatic wait_beat();
        int  b;
        bit  got;
        b   = 0;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
            b++;
            if (b > 2000) begin
                errors++;
                $display("FAIL beat_timeout: s_axis_tready low for %0d cycles, required a beat", b);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "stalled");
            end
        end
    endtask

    task automatic send_frame(input int njunk, input int gapmax, input int limit);
        for (int j = 0; j < njunk; j++) begin
            s_tdata = 8'hEE; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
            wait_beat();
        end
        for (int i = 0; i < limit; i++) begin
            s_tdata  = frm[i];
            s_tuser  = (i == 0);
            s_tlast  = (i == frm.size() - 1);
            s_tvalid = 1'b1;
            wait_beat();
            if (gapmax > 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, gapmax)) @(posedge clk);
                #1;
            end
        end
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int njunk, input int gapmax);
        model_frame();
        send_frame(njunk, gapmax, frm.size());
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " hdr_valid"}, n_hv, e_hv);
        chk({tag, " hdr_drop"},  n_drop, e_drop);
        chk({tag, " err_trunc"}, n_trunc, e_trunc);
        chk({tag, " drained"},   exp_q.size(), 0);
        chk({tag, " src"},       src_addr, m_src);
        chk({tag, " totlen"},    32'(tot_len), 32'(m_tl));
    endtask

    int v0, s0, plen, pad;

    initial begin
        rst = 1'b1; ip_en = 1'b1; m_rdy_set = 1'b1;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst m_tvalid", 32'(m_tvalid), 0);
        chk("rst s_tready", 32'(s_tready), 1);
        chk("rst src",      src_addr, 0);
        chk("rst totlen",   32'(tot_len), 0);
        chk("rst pulses",   32'({hv, hd, et}), 0);

        // Bypass: everything mirrors combinationally
        ip_en = 1'b0; m_rdy_set = 1'b0;
        s_tdata = 8'hA5; s_tvalid = 1'b1; s_tuser = 1'b1; s_tlast = 1'b1;
        #1;
        chk("byp out", 32'({m_tdata, m_tvalid, m_tuser, m_tlast}), 32'({8'hA5, 3'b111}));
        chk("byp rdy0", 32'(s_tready), 0);
        m_rdy_set = 1'b1;
        #1;
        chk("byp rdy1", 32'(s_tready), 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; ip_en = 1'b1;
        @(posedge clk);
        #1;

        // Worked example header and the bench's header builder must agree
        mk_hdr(8'h45, 16'h0024, 8'd17, 32'hC0A8_010A, LOCAL, 1'b0);
        chk("gen csum", 32'({frm[10], frm[11]}), 32'h0000_B70A);

        // Good datagram, 16 payload bytes 00..0F
        load_t1(); add_pay(16, 8'h00);
        run_frame("good", 0, 0);
        chk("good lit src", src_addr, 32'hC0A8_010A);
        chk("good lit totlen", 32'(tot_len), 32'h0000_0024);
        chk("good lit nout", n_out, 16);
        chk("good lit nhv", n_hv, 1);

        // Same datagram plus 10 pad bytes, then a frame after junk bytes
        load_t1(); add_pay(16, 8'h00);
        for (int i = 0; i < 10; i++) frm.push_back(8'hAA);
        run_frame("pad", 0, 0);
        chk("pad lit nout", n_out, 32);
        mk_hdr(8'h45, 16'd24, 8'd17, 32'h0A00_0001, LOCAL, 1'b0); add_pay(4, 8'h50);
        run_frame("after pad", 2, 0);

        // Corrupted checksum: no output and no stall with m_tready low
        load_t1(); add_pay(16, 8'h00); frm[11] = 8'h0B;
        v0 = n_vld; s0 = n_stall; m_rdy_set = 1'b0;
        run_frame("badcs", 0, 0);
        chk("badcs no out", n_vld - v0, 0);
        chk("badcs no stall", n_stall - s0, 0);
        chk("badcs lit drops", n_drop, 1);
        m_rdy_set = 1'b1;

        // Wrong destination, then broadcast
        mk_hdr(8'h45, 16'd28, 8'd17, 32'h0102_0304, 32'hC0A8_0165, 1'b0); add_pay(8, 8'h10);
        run_frame("dst other", 0, 0);
        mk_hdr(8'h45, 16'd28, 8'd17, 32'h0102_0305, 32'hFFFF_FFFF, 1'b0); add_pay(8, 8'h20);
        run_frame("dst bcast", 0, 0);

        // Other rejections
        mk_hdr(8'h46, 16'd28, 8'd17, 32'h1, LOCAL, 1'b0); add_pay(8, 8'h0);
        run_frame("bad ver", 0, 0);
        mk_hdr(8'h45, 16'd28, 8'd6, 32'h2, LOCAL, 1'b0); add_pay(8, 8'h0);
        run_frame("bad proto", 0, 0);
        mk_hdr(8'h45, 16'd20, 8'd17, 32'h3, LOCAL, 1'b0); add_pay(4, 8'h0);
        run_frame("totlen20", 0, 0);
        load_t1(); while (frm.size() > 11) void'(frm.pop_back());
        run_frame("hdr trunc", 0, 0);
        frm.delete(); frm.push_back(8'h45);
        run_frame("one byte", 0, 0);

        // Truncated payload: tlast on 8th of 16 bytes
        load_t1(); add_pay(8, 8'h40);
        run_frame("trunc", 0, 0);
        chk("trunc lit", n_trunc, 1);

        // Throttled random traffic
        throttle = 1'b1;
        for (int f = 0; f < 100; f++) begin
            plen = $urandom_range(1, 40);
            pad  = $urandom_range(0, 4);
            mk_hdr(8'h45, 16'(20 + plen), 8'd17, $urandom,
                   (f % 7 == 0) ? 32'hFFFF_FFFF : LOCAL, 1'b0);
            for (int i = 0; i < plen + pad; i++) frm.push_back(8'($urandom));
            run_frame("rnd", $urandom_range(0, 1), 2);
        end
        throttle = 1'b0;

        // Reset in the middle of a payload
        load_t1(); add_pay(16, 8'h30);
        model_frame();
        send_frame(0, 0, 25);
        rst = 1'b1;
        exp_q.delete(); m_src = 32'd0; m_tl = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst src", src_addr, 0);
        chk("midrst m_tvalid", 32'(m_tvalid), 0);
        chk("midrst s_tready", 32'(s_tready), 1);
        mk_hdr(8'h45, 16'd30, 8'd17, 32'hC0A8_0A0B, LOCAL, 1'b0); add_pay(10, 8'h60);
        run_frame("after rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
